// File: rtl/memory_unit.sv
// memory_unit: word-addressed data RAM behind a load/store port; MEMORY_UNIT_ERR_EN adds the addrErr flag
module memory_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              isLd,
  input  logic              isSt,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] op2,
`ifdef MEMORY_UNIT_ERR_EN
  output logic              addrErr,
`endif
  output logic [DATA_W-1:0] ldResult
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [ADDR_W-1:0] index;
  logic              inRange;
  logic [DATA_W-1:0] ldInit = '0;
  assign index   = aluResult[ADDR_W+1:2];
  assign inRange = aluResult[DATA_W-1:ADDR_W+2] == '0;
  assign ldResult = ldInit;
  // Both the read and the write use the pre-edge array, giving read-before-write on a shared edge.
  always_ff @(posedge clk)
    if (!reset && isSt && inRange) mem[index] <= op2;
  always_ff @(posedge clk)
    if (reset) ldInit <= '0;
    else if (isLd) ldInit <= inRange ? mem[index] : '0;
`ifdef MEMORY_UNIT_ERR_EN
  always_ff @(posedge clk)
    addrErr <= reset ? 1'b0 : (isLd | isSt) & ((aluResult[1:0] != 2'b00) | !inRange);
`else
  logic unusedLsbs;
  assign unusedLsbs = ^aluResult[1:0];
`endif
endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: scoreboard bench for memory_unit; addrErr is checked when MEMORY_UNIT_ERR_EN is defined
module tb_memory_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        isLd = 1'b0;
  logic        isSt = 1'b0;
  logic [31:0] aluResult = '0;
  logic [31:0] op2 = '0;
  logic [31:0] ldResult;
`ifdef MEMORY_UNIT_ERR_EN
  logic        addrErr;
`endif
  bit          issued = 1'b0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    bit          chk;
    logic [31:0] ld;
    bit          err;
    string       nm;
  } exp_t;
  exp_t sbq[$];

  memory_unit #(.DATA_W(32), .DEPTH(1024)) dut (
    .clk(clk),
    .reset(reset),
    .isLd(isLd),
    .isSt(isSt),
    .aluResult(aluResult),
    .op2(op2),
`ifdef MEMORY_UNIT_ERR_EN
    .addrErr(addrErr),
`endif
    .ldResult(ldResult)
  );

  always #5 clk = ~clk;

  task automatic step(input bit ld, input bit st, input bit rs, input logic [31:0] a,
                      input logic [31:0] d, input bit chk, input logic [31:0] expLd,
                      input bit expErr, input string nm);
    @(negedge clk);
    isLd = ld;
    isSt = st;
    reset = rs;
    aluResult = a;
    op2 = d;
    issued = 1'b1;
    sbq.push_back('{chk: chk, ld: expLd, err: expErr, nm: nm});
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (issued) begin
        #1;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty: got output with no expectation queued");
        end else begin
          e = sbq.pop_front();
          if (e.chk) begin
            total++;
            if (ldResult !== e.ld) begin
              bad++;
              $display("FAIL %s: ldResult=%h expected=%h", e.nm, ldResult, e.ld);
            end
          end
`ifdef MEMORY_UNIT_ERR_EN
          total++;
          if (addrErr !== e.err) begin
            bad++;
            $display("FAIL %s_err: addrErr=%b expected=%b", e.nm, addrErr, e.err);
          end
`endif
        end
      end
    end
  end

  initial begin
    step(0, 0, 1, 32'h0,        32'h0,        1, 32'h0,        0, "reset");
    step(0, 1, 0, 32'h20,       32'hCAFEBABE, 0, 32'h0,        0, "t1_st");
    step(1, 0, 0, 32'h20,       32'h0,        1, 32'hCAFEBABE, 0, "t1_load");
    step(0, 0, 0, 32'h0,        32'h0,        1, 32'hCAFEBABE, 0, "t1_hold1");
    step(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, "t1_idle");
    step(0, 0, 0, 32'h0,        32'h0,        1, 32'hCAFEBABE, 0, "t1_hold3");
    step(1, 0, 0, 32'h40,       32'h0,        1, 32'h0,        0, "t2_unwritten");
    step(0, 1, 0, 32'h40,       32'h12345678, 0, 32'h0,        0, "t2_st");
    step(1, 0, 0, 32'h40,       32'h0,        1, 32'h12345678, 0, "t2_b2b");
    step(0, 1, 0, 32'h24,       32'h11111111, 0, 32'h0,        0, "t3_st");
    step(1, 1, 0, 32'h24,       32'h22222222, 1, 32'h11111111, 0, "t3_rbw");
    step(1, 0, 0, 32'h24,       32'h0,        1, 32'h22222222, 0, "t3_new");
    step(0, 1, 0, 32'h23,       32'hDEADBEEF, 0, 32'h0,        1, "t4_st_unaligned");
    step(1, 0, 0, 32'h20,       32'h0,        1, 32'hDEADBEEF, 0, "t4_aligned");
    step(1, 0, 0, 32'h22,       32'h0,        1, 32'hDEADBEEF, 1, "t4_ld_unaligned");
    step(0, 1, 0, 32'h1000,     32'hA5A5A5A5, 0, 32'h0,        1, "t5_st_oor");
    step(1, 0, 0, 32'h1000,     32'h0,        1, 32'h0,        1, "t5_ld_oor");
    step(1, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0, "t5_word0");
    step(1, 0, 0, 32'h80000020, 32'h0,        1, 32'h0,        1, "t5_high_bit");
    step(0, 1, 0, 32'hFFC,      32'h0BADF00D, 0, 32'h0,        0, "last_st");
    step(1, 0, 0, 32'hFFC,      32'h0,        1, 32'h0BADF00D, 0, "last_word");
    step(0, 1, 0, 32'h20,       32'hCAFEBABE, 0, 32'h0,        0, "t6_st");
    step(1, 0, 0, 32'h20,       32'h0,        1, 32'hCAFEBABE, 0, "t6_load");
    step(1, 1, 1, 32'h20,       32'h0,        1, 32'h0,        0, "t6_reset");
    step(1, 0, 0, 32'h20,       32'h0,        1, 32'hCAFEBABE, 0, "t6_ram_kept");
    @(negedge clk);
    issued = 1'b0;
    isLd = 1'b0;
    isSt = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left expected=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
